// File: rtl/icache_pkg.sv
// +------------------------------------------------------------------------+
// | Module      : icache_pkg                                               |
// | Description : Shared constants, FSM encodings and defaults for icache. |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
`default_nettype none

package icache_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int ICACHE_LINES      = 64;
    localparam int ICACHE_LINE_WORDS = 4;
    localparam int DATA_W            = 32;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REFILL  = 2'd1;
    localparam logic [1:0] S_RESPOND = 2'd2;

    // Byte-offset bits covered by one line.
    function automatic int off_bits(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/icache_data_array.sv
// +------------------------------------------------------------------------+
// | Module      : icache_data_array                                        |
// | Description : Line data, tag and valid storage; async read, one write. |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
`default_nettype none

module icache_data_array
    import icache_pkg::*;
#(
    parameter int LINES      = ICACHE_LINES,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int TAG_W      = 32 - off_bits(ICACHE_LINE_WORDS) - $clog2(ICACHE_LINES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [$clog2(LINES)-1:0]      rd_idx,
    input  logic [$clog2(LINE_WORDS)-1:0] rd_off,
    output logic [DATA_W-1:0]             rd_data,
    output logic [TAG_W-1:0]              rd_tag,
    output logic                          rd_valid,
    input  logic                          wr_en,
    input  logic [$clog2(LINES)-1:0]      wr_idx,
    input  logic [$clog2(LINE_WORDS)-1:0] wr_off,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          tag_wr_en,
    input  logic [TAG_W-1:0]              tag_wr
);

    logic [DATA_W-1:0] data_q [LINES*LINE_WORDS];
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  valid_d;

    assign rd_data  = data_q[{rd_idx, rd_off}];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_valid = valid_q[rd_idx];

    always_comb begin
        valid_d = valid_q;
        if (tag_wr_en) begin
            valid_d[wr_idx] = TRUE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[{wr_idx, wr_off}] <= wr_data;
        end
        if (tag_wr_en) begin
            tag_q[wr_idx] <= tag_wr;
        end
    end

    // Only the valid bits need clearing; stale data/tags are never trusted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/icache.sv
// +------------------------------------------------------------------------+
// | Module      : icache                                                   |
// | Description : Direct-mapped read-only instruction cache with line      |
// |               refill; optional hit/miss counters via ICACHE_STAT_EN.   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
`default_nettype none

module icache
    import icache_pkg::*;
#(
    parameter int LINES      = ICACHE_LINES,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        fetch_rdy,
    input  logic [31:0] fetch_pc,
    input  logic        flush,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_word_valid,
    input  logic [31:0] mem_word
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int OFF_BITS = off_bits(LINE_WORDS);
    localparam int WOFF_W   = $clog2(LINE_WORDS);
    localparam int IDX_W    = $clog2(LINES);
    localparam int IDX_HI   = OFF_BITS + IDX_W - 1;
    localparam int TAG_W    = 32 - OFF_BITS - IDX_W;
    localparam logic [WOFF_W-1:0] LAST_CNT = WOFF_W'(LINE_WORDS - 1);

    logic [1:0]        state_q, state_d;
    logic [31:0]       req_pc_q, req_pc_d;
    logic [WOFF_W-1:0] cnt_q, cnt_d;
    logic              squash_q, squash_d;
    logic              valid_q, valid_d;
    logic [31:0]       instr_out_q, instr_out_d;
    logic              mem_req_q, mem_req_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       resp_word_q, resp_word_d;

    logic [IDX_W-1:0]  fetch_idx;
    logic [WOFF_W-1:0] fetch_off;
    logic [TAG_W-1:0]  fetch_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WOFF_W-1:0] req_off;
    logic [TAG_W-1:0]  req_tag;
    logic [31:0]       rd_data;
    logic [TAG_W-1:0]  rd_tag;
    logic              rd_valid;
    logic              hit;
    logic              accept;
    logic              word_take;
    logic              last_word;
    logic              arr_wr_en;
    logic              arr_tag_wr_en;
    logic              hit_inc;
    logic              miss_inc;
    logic [3:0]        unused_pc_bits;

    assign fetch_idx = fetch_pc[IDX_HI:OFF_BITS];
    assign fetch_off = fetch_pc[OFF_BITS-1:2];
    assign fetch_tag = fetch_pc[31:IDX_HI+1];
    assign req_idx   = req_pc_q[IDX_HI:OFF_BITS];
    assign req_off   = req_pc_q[OFF_BITS-1:2];
    assign req_tag   = req_pc_q[31:IDX_HI+1];
    assign unused_pc_bits = {fetch_pc[1:0], req_pc_q[1:0]};

    assign hit       = rd_valid && (rd_tag == fetch_tag);
    assign accept    = (state_q == S_IDLE) && fetch_rdy && !flush;
    assign word_take = (state_q == S_REFILL) && mem_word_valid;
    assign last_word = word_take && (cnt_q == LAST_CNT);

    assign arr_wr_en     = rdy && word_take;
    assign arr_tag_wr_en = rdy && last_word;

    icache_data_array #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W)
    ) u_data_array (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (fetch_idx),
        .rd_off    (fetch_off),
        .rd_data   (rd_data),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .wr_en     (arr_wr_en),
        .wr_idx    (req_idx),
        .wr_off    (cnt_q),
        .wr_data   (mem_word),
        .tag_wr_en (arr_tag_wr_en),
        .tag_wr    (req_tag)
    );

    always_comb begin
        state_d     = state_q;
        req_pc_d    = req_pc_q;
        cnt_d       = cnt_q;
        squash_d    = squash_q;
        valid_d     = FALSE;
        instr_out_d = instr_out_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        resp_word_d = resp_word_q;
        hit_inc     = FALSE;
        miss_inc    = FALSE;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    req_pc_d = fetch_pc;
                    if (hit) begin
                        valid_d     = TRUE;
                        instr_out_d = rd_data;
                        hit_inc     = TRUE;
                    end else begin
                        state_d    = S_REFILL;
                        mem_req_d  = TRUE;
                        mem_addr_d = {fetch_pc[31:OFF_BITS], {OFF_BITS{1'b0}}};
                        cnt_d      = '0;
                        squash_d   = FALSE;
                        miss_inc   = TRUE;
                    end
                end
            end
            S_REFILL: begin
                if (flush) begin
                    squash_d = TRUE;
                end
                if (word_take) begin
                    cnt_d = cnt_q + WOFF_W'(1);
                    if (cnt_q == req_off) begin
                        resp_word_d = mem_word;
                    end
                    if (last_word) begin
                        mem_req_d = FALSE;
                        state_d   = S_RESPOND;
                        // The requested word may be arriving right now.
                        if (!(squash_q || flush)) begin
                            valid_d     = TRUE;
                            instr_out_d = (req_off == LAST_CNT) ? mem_word : resp_word_q;
                        end
                    end
                end
            end
            S_RESPOND: begin
                state_d  = S_IDLE;
                squash_d = FALSE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            req_pc_q    <= '0;
            cnt_q       <= '0;
            squash_q    <= FALSE;
            valid_q     <= FALSE;
            instr_out_q <= '0;
            mem_req_q   <= FALSE;
            mem_addr_q  <= '0;
            resp_word_q <= '0;
        end else if (rdy) begin
            state_q     <= state_d;
            req_pc_q    <= req_pc_d;
            cnt_q       <= cnt_d;
            squash_q    <= squash_d;
            valid_q     <= valid_d;
            instr_out_q <= instr_out_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            resp_word_q <= resp_word_d;
        end
    end

    // A flush in the pulse cycle (post-hit IDLE or RESPOND) kills the result.
    assign instr_valid = valid_q && !flush;
    assign instr_out   = instr_out_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;

`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q + {31'd0, hit_inc};
        miss_cnt_d = miss_cnt_q + {31'd0, miss_inc};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rdy) begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    logic unused_stat;
    assign unused_stat = hit_inc ^ miss_inc;
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// +------------------------------------------------------------------------+
// | Module      : tb_icache                                                |
// | Description : Directed self-checking bench for icache.                 |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_icache;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        fetch_rdy;
    logic [31:0] fetch_pc;
    logic        flush;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_word_valid;
    logic [31:0] mem_word;
`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    icache dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .fetch_rdy      (fetch_rdy),
        .fetch_pc       (fetch_pc),
        .flush          (flush),
        .instr_valid    (instr_valid),
        .instr_out      (instr_out),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_word_valid (mem_word_valid),
        .mem_word       (mem_word)
`ifdef ICACHE_STAT_EN
        ,
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic quiet();
        fetch_rdy      = 1'b0;
        mem_word_valid = 1'b0;
        flush          = 1'b0;
        tick();
    endtask

    task automatic fetch(input logic [31:0] pc);
        fetch_rdy = 1'b1;
        fetch_pc  = pc;
        tick();
        fetch_rdy = 1'b0;
    endtask

    task automatic feed(input logic [31:0] w);
        mem_word_valid = 1'b1;
        mem_word       = w;
        tick();
        mem_word_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; fetch_rdy = 1'b0; fetch_pc = '0;
        flush = 1'b0; mem_word_valid = 1'b0; mem_word = '0;
        tick();
        tick();
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_out", instr_out, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
`ifdef ICACHE_STAT_EN
        chk("rst_hits", hit_cnt, 32'd0);
        chk("rst_miss", miss_cnt, 32'd0);
`endif
        rst = 1'b1;
        tick();

        // 1: cold miss
        fetch(32'h0000_0000);
        chk("t1_req", {31'd0, mem_req}, 32'd1);
        chk("t1_addr", mem_addr, 32'h0);
        chk("t1_novalid", {31'd0, instr_valid}, 32'd0);
        feed(32'h11); feed(32'h22); feed(32'h33);
        chk("t1_req_held", {31'd0, mem_req}, 32'd1);
        feed(32'h44);
        chk("t1_valid", {31'd0, instr_valid}, 32'd1);
        chk("t1_out", instr_out, 32'h11);
        chk("t1_req_drop", {31'd0, mem_req}, 32'd0);
        quiet();
        chk("t1_pulse_end", {31'd0, instr_valid}, 32'd0);

        // 2: hit streak
        fetch_rdy = 1'b1; fetch_pc = 32'h4; tick();
        chk("t2_v0", {31'd0, instr_valid}, 32'd1);
        chk("t2_d0", instr_out, 32'h22);
        fetch_pc = 32'h8; tick();
        chk("t2_v1", {31'd0, instr_valid}, 32'd1);
        chk("t2_d1", instr_out, 32'h33);
        fetch_pc = 32'hC; tick();
        chk("t2_v2", {31'd0, instr_valid}, 32'd1);
        chk("t2_d2", instr_out, 32'h44);
        chk("t2_noreq", {31'd0, mem_req}, 32'd0);
        quiet();
        chk("t2_end", {31'd0, instr_valid}, 32'd0);

        // 3: conflict on index 0
        fetch(32'h400);
        chk("t3_req", {31'd0, mem_req}, 32'd1);
        chk("t3_addr", mem_addr, 32'h400);
        feed(32'hA0); feed(32'hA1); feed(32'hA2); feed(32'hA3);
        chk("t3_out", instr_out, 32'hA0);
        quiet();
        fetch(32'h0);
        chk("t3_remiss", {31'd0, mem_req}, 32'd1);
        chk("t3_addr0", mem_addr, 32'h0);
        feed(32'h11); feed(32'h22); feed(32'h33); feed(32'h44);
        chk("t3_out0", instr_out, 32'h11);
        quiet();

        // 4: flush mid-refill
        fetch(32'h40);
        chk("t4_addr", mem_addr, 32'h40);
        feed(32'h51); feed(32'h52);
        flush = 1'b1; tick(); flush = 1'b0;
        feed(32'h53); feed(32'h54);
        chk("t4_squashed", {31'd0, instr_valid}, 32'd0);
        chk("t4_req_drop", {31'd0, mem_req}, 32'd0);
        quiet();
        fetch(32'h44);
        chk("t4_hit_v", {31'd0, instr_valid}, 32'd1);
        chk("t4_hit_d", instr_out, 32'h52);
        chk("t4_hit_noreq", {31'd0, mem_req}, 32'd0);
        quiet();

        // 5: rdy stall during refill
        fetch(32'h80);
        feed(32'h61);
        rdy = 1'b0;
        mem_word_valid = 1'b1; mem_word = 32'hE1; tick();
        chk("t5_stall_req", {31'd0, mem_req}, 32'd1);
        mem_word_valid = 1'b0; tick();
        mem_word_valid = 1'b1; mem_word = 32'hE3; tick();
        chk("t5_stall_addr", mem_addr, 32'h80);
        chk("t5_stall_v", {31'd0, instr_valid}, 32'd0);
        mem_word_valid = 1'b0;
        rdy = 1'b1;
        feed(32'h62); feed(32'h63);
        chk("t5_cnt_held", {31'd0, mem_req}, 32'd1);
        feed(32'h64);
        chk("t5_done", {31'd0, mem_req}, 32'd0);
        chk("t5_out", instr_out, 32'h61);
        quiet();
        fetch(32'h88);
        chk("t5_hit", instr_out, 32'h63);
        quiet();

        // 6: reset mid-refill
        fetch(32'hC0);
        chk("t6_req", {31'd0, mem_req}, 32'd1);
`ifdef ICACHE_STAT_EN
        chk("t6_hits", hit_cnt, 32'd5);
        chk("t6_miss", miss_cnt, 32'd6);
`endif
        feed(32'h71);
        rst = 1'b0; tick();
        chk("t6_req_abort", {31'd0, mem_req}, 32'd0);
        chk("t6_addr_clr", mem_addr, 32'd0);
`ifdef ICACHE_STAT_EN
        chk("t6_hits_clr", hit_cnt, 32'd0);
        chk("t6_miss_clr", miss_cnt, 32'd0);
`endif
        rst = 1'b1; tick();
        fetch(32'h0);
        chk("t6_cold", {31'd0, mem_req}, 32'd1);
        chk("t6_cold_v", {31'd0, instr_valid}, 32'd0);
        feed(32'h91); feed(32'h92); feed(32'h93); feed(32'h94);
        chk("t6_out", instr_out, 32'h91);
        quiet();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
